// File: rtl/vending_machine_param.sv
// Parametrised multi-product vending controller: saturating credit, per-product
// prices, cancel, and largest-denomination-first change return.
module vending_machine_param #(
    parameter int unsigned                  NUM_PROD   = 4,
    parameter int unsigned                  SEL_W      = 2,
    parameter int unsigned                  PRICE_W    = 8,
    parameter logic [NUM_PROD*PRICE_W-1:0]  PRICES     = {8'd15, 8'd10, 8'd7, 8'd5},
    parameter int unsigned                  MAX_CREDIT = 50
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               coin_valid,
    input  logic [1:0]         coin,
    input  logic               buy,
    input  logic [SEL_W-1:0]   sel,
    input  logic               cancel,
    output logic               product,
    output logic [SEL_W-1:0]   product_id,
    output logic               change,
    output logic [1:0]         change_coin,
    output logic [PRICE_W-1:0] credit,
    output logic               busy,
    output logic               coin_reject,
    output logic               insufficient,
    output logic               sel_err
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_VEND    = 2'd2,
        S_CHANGE  = 2'd3
    } state_t;

    localparam logic [PRICE_W:0]   MAX_C = (PRICE_W+1)'(MAX_CREDIT);
    localparam logic [PRICE_W-1:0] D1    = PRICE_W'(1);
    localparam logic [PRICE_W-1:0] D2    = PRICE_W'(2);
    localparam logic [PRICE_W-1:0] D5    = PRICE_W'(5);
    localparam logic [PRICE_W-1:0] D10   = PRICE_W'(10);

    state_t             state_q;
    logic [PRICE_W-1:0] credit_q;
    logic               product_q;
    logic [SEL_W-1:0]   product_id_q;
    logic               change_q;
    logic [1:0]         change_coin_q;
    logic               busy_q;
    logic               coin_reject_q;
    logic               insufficient_q;
    logic               sel_err_q;

    logic [PRICE_W-1:0] coin_val;
    logic [PRICE_W:0]   coin_sum;
    logic               coin_fits;
    logic               sel_ok;
    logic [PRICE_W-1:0] sel_price;
    logic [1:0]         chg_code;
    logic [PRICE_W-1:0] chg_val;
    logic [PRICE_W-1:0] chg_rem;

    always_comb begin
        unique case (coin)
            2'b00:   coin_val = D1;
            2'b01:   coin_val = D2;
            2'b10:   coin_val = D5;
            default: coin_val = D10;
        endcase
        coin_sum  = {1'b0, credit_q} + {1'b0, coin_val};
        coin_fits = (coin_sum <= MAX_C);
    end

    always_comb begin
        sel_ok    = 1'b0;
        sel_price = '0;
        for (int unsigned i = 0; i < NUM_PROD; i++) begin
            if (sel == SEL_W'(i)) begin
                sel_ok    = 1'b1;
                sel_price = PRICES[i*PRICE_W +: PRICE_W];
            end
        end
    end

    always_comb begin
        if (credit_q >= D10) begin
            chg_code = 2'b11;
            chg_val  = D10;
        end else if (credit_q >= D5) begin
            chg_code = 2'b10;
            chg_val  = D5;
        end else if (credit_q >= D2) begin
            chg_code = 2'b01;
            chg_val  = D2;
        end else begin
            chg_code = 2'b00;
            chg_val  = D1;
        end
        chg_rem = credit_q - chg_val;
    end

    // The first change coin is issued on the same edge that accepts cancel or
    // leaves VEND, so change pulses follow with no idle cycle in between.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            credit_q       <= '0;
            product_q      <= 1'b0;
            product_id_q   <= '0;
            change_q       <= 1'b0;
            change_coin_q  <= '0;
            busy_q         <= 1'b0;
            coin_reject_q  <= 1'b0;
            insufficient_q <= 1'b0;
            sel_err_q      <= 1'b0;
        end else begin
            product_q      <= 1'b0;
            product_id_q   <= '0;
            change_q       <= 1'b0;
            change_coin_q  <= '0;
            coin_reject_q  <= 1'b0;
            insufficient_q <= 1'b0;
            sel_err_q      <= 1'b0;

            unique case (state_q)
                S_IDLE, S_COLLECT: begin
                    if (cancel && (credit_q != '0)) begin
                        change_q      <= 1'b1;
                        change_coin_q <= chg_code;
                        credit_q      <= chg_rem;
                        state_q       <= (chg_rem == '0) ? S_IDLE : S_CHANGE;
                        busy_q        <= (chg_rem != '0);
                        coin_reject_q <= coin_valid;
                    end else if (buy && sel_ok && (credit_q >= sel_price)) begin
                        product_q     <= 1'b1;
                        product_id_q  <= sel;
                        credit_q      <= credit_q - sel_price;
                        state_q       <= S_VEND;
                        busy_q        <= 1'b1;
                        coin_reject_q <= coin_valid;
                    end else begin
                        // A refused buy does not block a coin arriving with it.
                        if (buy) begin
                            sel_err_q      <= !sel_ok;
                            insufficient_q <= sel_ok;
                        end
                        if (coin_valid) begin
                            if (coin_fits) begin
                                credit_q <= coin_sum[PRICE_W-1:0];
                                state_q  <= S_COLLECT;
                            end else begin
                                coin_reject_q <= 1'b1;
                            end
                        end
                    end
                end

                S_VEND, S_CHANGE: begin
                    coin_reject_q <= coin_valid;
                    if (credit_q != '0) begin
                        change_q      <= 1'b1;
                        change_coin_q <= chg_code;
                        credit_q      <= chg_rem;
                        state_q       <= (chg_rem == '0) ? S_IDLE : S_CHANGE;
                        busy_q        <= (chg_rem != '0);
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q  <= S_IDLE;
                    credit_q <= '0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign product      = product_q;
    assign product_id   = product_id_q;
    assign change       = change_q;
    assign change_coin  = change_coin_q;
    assign credit       = credit_q;
    assign busy         = busy_q;
    assign coin_reject  = coin_reject_q;
    assign insufficient = insufficient_q;
    assign sel_err      = sel_err_q;

endmodule

// File: doc/vending_machine_param.md
# vending_machine_param

Parametrised multi-product vending controller with credit accumulation, denomination-based change return and cancel. It accepts coins of four denominations into a saturating credit register, vends one of NUM_PROD products at per-product prices, and returns change one coin per cycle using largest-denomination-first. It is the next-generation controller in the FSM vending-machine design family, driven by a coin acceptor and a product selector.

## Interface
- NUM_PROD, 4, number of products
- SEL_W, 2, width of product select; must satisfy 2^SEL_W >= NUM_PROD
- PRICE_W, 8, width of prices and credit
- PRICES, {8'd15,8'd10,8'd7,8'd5}, packed prices; product i occupies bits [i*PRICE_W +: PRICE_W], so product0=5, product1=7, product2=10, product3=15
- MAX_CREDIT, 50, credit ceiling; must be < 2^PRICE_W

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- coin_valid  in  1  coin present this cycle
- coin  in  2  denomination: 00=1, 01=2, 10=5, 11=10 units
- buy  in  1  purchase request, with sel
- sel  in  SEL_W  product index
- cancel  in  1  refund all credit
- product  out  1  one-cycle vend pulse
- product_id  out  SEL_W  index of the vended product; valid while product=1
- change  out  1  one-cycle pulse per returned coin
- change_coin  out  2  denomination of the returned coin, same encoding as coin
- credit  out  PRICE_W  current credit
- busy  out  1  high in VEND and CHANGE
- coin_reject  out  1  one-cycle pulse: coin refused
- insufficient  out  1  one-cycle pulse: buy with credit < price
- sel_err  out  1  one-cycle pulse: buy with sel >= NUM_PROD

## Operation
- States: IDLE (credit=0), COLLECT (credit>0), VEND, CHANGE.
- All outputs are registered. While rst is high, state=IDLE, credit=0 and every output is 0.
- Inputs are sampled in IDLE and COLLECT only. Same-cycle priority is cancel > buy > coin.
- **Coin acceptance:**
  - A coin is accepted if credit+value <= MAX_CREDIT. Credit then increases and the state becomes COLLECT.
  - Otherwise coin_reject pulses and credit is unchanged.
  - A coin that arrives in the same cycle as an accepted buy or cancel is rejected with coin_reject.
- **Buy:**
  - If sel >= NUM_PROD: sel_err pulses and the state is unchanged.
  - If credit < PRICES[sel]: insufficient pulses and the state is unchanged.
  - Otherwise the block goes to VEND and latches sel.
- **VEND (one cycle):**
  - product=1, product_id=latched sel, credit -= price.
  - Then go to CHANGE if the remainder is > 0, else IDLE.
- **Cancel:**
  - With credit > 0: go to CHANGE.
  - With credit = 0: ignored.
- **CHANGE:**
  - Each cycle: change=1 and change_coin = the largest denomination <= credit; credit is decremented by that value.
  - When credit reaches 0, go to IDLE.
- In VEND and CHANGE, buy and cancel are ignored and every coin_valid produces coin_reject. No credit is ever lost or created.
- Arithmetic: credit is unsigned PRICE_W bits. The MAX_CREDIT check prevents overflow, and the price check prevents underflow.

## Timing
- A coin sampled at edge N updates credit after edge N.
- A buy accepted at edge N gives product=1 in the cycle after N (one cycle wide). The first change pulse appears the following cycle, then one pulse per cycle with no gaps.
- Cancel accepted at edge N: the first change pulse appears in the cycle after N.
- Worst-case change length: MAX_CREDIT=50 gives 5 pulses.
- rst asserted mid-VEND or mid-CHANGE clears all outputs and credit immediately, without waiting for clk. Residual credit is discarded.
- coin_reject, insufficient and sel_err appear in the cycle after the offending sample and are one cycle wide.

## Test plan
- Exact payment: reset, then coins 10,10 (two 5s), then buy sel=2. Expect credit=10, then product=1 with product_id=2, then credit=0 and IDLE with no change pulses.
- Change: coins 11,11 (credit 20), then buy sel=1 (price 7). Expect a product pulse, then change_coin 11, 01, 00 on 3 consecutive cycles (10+2+1=13), then credit=0.
- Insufficient, then cancel: coins 01,00 (credit 3), then buy sel=0. Expect insufficient=1 and credit stays 3. Then cancel: expect change_coin 01 then 00, then IDLE.
- Saturation: five 11 coins give credit=50. A sixth coin gives coin_reject=1 and credit=50. Then buy sel=3: expect change 11,11,11,10 (35).
- Select error and simultaneity: buy sel=3 with NUM_PROD=3 gives sel_err=1. With credit 10, buy sel=0 plus coin 11 in the same cycle gives a vend plus coin_reject, and change 10 (5).
- Busy behaviour and reset: a coin during CHANGE gives coin_reject and the change sequence is unaltered. Asserting rst mid-CHANGE forces all outputs and credit to 0 asynchronously; after release the block is in IDLE.
